// File: rtl/matrix_win_ctrl_if.sv
// rtl/matrix_win_ctrl_if.sv - line FIFO pair bus between matrix_win_ctrl (master) and its two line FIFOs (slave)
interface matrix_win_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  f0_wr_en;
   logic                  f0_rd_en;
   logic [DATA_WIDTH-1:0] f0_wr_data;
   logic [DATA_WIDTH-1:0] f0_rd_data;
   logic                  f0_full;
   logic                  f0_empty;
   logic                  f1_wr_en;
   logic                  f1_rd_en;
   logic [DATA_WIDTH-1:0] f1_wr_data;
   logic [DATA_WIDTH-1:0] f1_rd_data;
   logic                  f1_full;
   logic                  f1_empty;

   modport master (
      output f0_wr_en, f0_rd_en, f0_wr_data, f1_wr_en, f1_rd_en, f1_wr_data,
      input  f0_rd_data, f0_full, f0_empty, f1_rd_data, f1_full, f1_empty
   );

   modport slave (
      input  f0_wr_en, f0_rd_en, f0_wr_data, f1_wr_en, f1_rd_en, f1_wr_data,
      output f0_rd_data, f0_full, f0_empty, f1_rd_data, f1_full, f1_empty
   );
endinterface

// File: rtl/matrix_win_ctrl.sv
// rtl/matrix_win_ctrl.sv - raster-to-3-row-column sequencer driving two line FIFOs
// Optional FIFO protocol checking and ERR state: define MATRIX_WIN_CTRL_ERR_CHK_EN.
module matrix_win_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 416,
   parameter int IMG_HEIGHT = 416,
   parameter int CNT_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sof,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   matrix_win_ctrl_if.master     fifo,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_r0,
   output logic [DATA_WIDTH-1:0] out_r1,
   output logic [DATA_WIDTH-1:0] out_r2,
   output logic [CNT_WIDTH-1:0]  out_col,
   output logic                  frame_done,
   output logic                  err
);
   localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
   localparam logic [CNT_WIDTH-1:0] ROW_WR_LAST = CNT_WIDTH'(IMG_HEIGHT - 2);

   typedef enum logic [2:0] {IDLE, FILL, RUN, DONE, ERR} state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  row;
   logic [CNT_WIDTH-1:0]  col;
   logic [DATA_WIDTH-1:0] pix_b;
   logic                  accept;
   logic                  last_col;
   logic                  last_pix;
   logic                  err_det;

   // Stage A: combinational handshake and FIFO reads for the beat being accepted.
   assign in_ready      = ((state == FILL) || (state == RUN)) && !fifo.f0_full && !fifo.f1_full;
   assign accept        = in_valid && in_ready;
   assign last_col      = (col == COL_LAST);
   assign last_pix      = last_col && (row == ROW_LAST);
   assign fifo.f0_rd_en = accept && (row >= CNT_WIDTH'(1));
   assign fifo.f1_rd_en = accept && (row >= CNT_WIDTH'(2));

   // Stage B: FIFO read data lands this cycle, so it is forwarded, not registered.
   assign fifo.f0_wr_data = pix_b;
   assign fifo.f1_wr_data = fifo.f1_wr_en ? fifo.f0_rd_data : '0;
   assign out_r2          = pix_b;
   assign out_r1          = out_valid ? fifo.f0_rd_data : '0;
   assign out_r0          = out_valid ? fifo.f1_rd_data : '0;

`ifdef MATRIX_WIN_CTRL_ERR_CHK_EN
   assign err_det = (fifo.f0_rd_en && fifo.f0_empty) || (fifo.f1_rd_en && fifo.f1_empty) ||
                    (fifo.f0_wr_en && fifo.f0_full)  || (fifo.f1_wr_en && fifo.f1_full)  ||
                    ((state == DONE) && (!fifo.f0_empty || !fifo.f1_empty));
`else
   logic unused_flags;
   assign unused_flags = fifo.f0_empty ^ fifo.f1_empty;
   assign err_det      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         row           <= '0;
         col           <= '0;
         pix_b         <= '0;
         out_col       <= '0;
         out_valid     <= 1'b0;
         frame_done    <= 1'b0;
         fifo.f0_wr_en <= 1'b0;
         fifo.f1_wr_en <= 1'b0;
         err           <= 1'b0;
      end else begin
         fifo.f0_wr_en <= accept && (row <= ROW_WR_LAST);
         fifo.f1_wr_en <= accept && (row >= CNT_WIDTH'(1)) && (row <= ROW_WR_LAST);
         out_valid     <= accept && (row >= CNT_WIDTH'(2));
         frame_done    <= accept && last_pix;
         if (accept) begin
            pix_b   <= in_data;
            out_col <= col;
            if (last_col) begin
               col <= '0;
               row <= row + CNT_WIDTH'(1);
            end else begin
               col <= col + CNT_WIDTH'(1);
            end
         end
         case (state)
            IDLE: if (sof) begin
               state <= FILL;
               row   <= '0;
               col   <= '0;
            end
            FILL: if (accept && last_col && (row == CNT_WIDTH'(1))) state <= RUN;
            RUN:  if (accept && last_pix) state <= DONE;
            DONE: state <= IDLE;
            ERR:  if (sof) begin
               state <= IDLE;
               err   <= 1'b0;
               row   <= '0;
               col   <= '0;
            end
            default: state <= IDLE;
         endcase
         if (err_det) begin
            state <= ERR;
            err   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_matrix_win_ctrl.sv
// tb/tb_matrix_win_ctrl.sv - scoreboard bench for matrix_win_ctrl on a 4x4 frame with queue-based line FIFOs
module tb_matrix_win_ctrl;
   localparam int DW    = 8;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int CW    = 10;
   localparam int DEPTH = 1024;

   typedef struct packed {
      logic          done;
      logic [CW-1:0] col;
      logic [DW-1:0] r0;
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sof = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_r0, out_r1, out_r2;
   logic [CW-1:0] out_col;
   logic          frame_done;
   logic          err;

   matrix_win_ctrl_if #(.DATA_WIDTH(DW)) fifo_bus ();

   matrix_win_ctrl #(
      .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .fifo(fifo_bus), .out_valid(out_valid), .out_r0(out_r0),
      .out_r1(out_r1), .out_r2(out_r2), .out_col(out_col), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural line FIFOs: read data registered one cycle after rd_en.
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   int            c0 = 0;
   int            c1 = 0;
   logic          frc_f0_full = 1'b0;
   logic          frc_f1_empty = 1'b0;

   assign fifo_bus.f0_full  = frc_f0_full || (c0 >= DEPTH);
   assign fifo_bus.f0_empty = (c0 == 0);
   assign fifo_bus.f1_full  = (c1 >= DEPTH);
   assign fifo_bus.f1_empty = frc_f1_empty || (c1 == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         c0 <= 0;
         c1 <= 0;
         fifo_bus.f0_rd_data <= '0;
         fifo_bus.f1_rd_data <= '0;
      end else begin
         if (fifo_bus.f0_rd_en && q0.size() > 0) fifo_bus.f0_rd_data <= q0.pop_front();
         if (fifo_bus.f1_rd_en && q1.size() > 0) fifo_bus.f1_rd_data <= q1.pop_front();
         if (fifo_bus.f0_wr_en) q0.push_back(fifo_bus.f0_wr_data);
         if (fifo_bus.f1_wr_en) q1.push_back(fifo_bus.f1_wr_data);
         c0 <= q0.size();
         c1 <= q1.size();
      end
   end

   int            errors = 0;
   int            checks = 0;
   int            n_out = 0;
   exp_t          sb[$];
   logic [DW-1:0] img [H][W];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check("out_r0", 32'(out_r0), 32'(e.r0));
               check("out_r1", 32'(out_r1), 32'(e.r1));
               check("out_r2", 32'(out_r2), 32'(e.r2));
               check("out_col", 32'(out_col), 32'(e.col));
               check("frame_done", 32'(frame_done), 32'(e.done));
            end
         end else if (frame_done) begin
            check("frame_done_stray", 32'(1), 32'(0));
         end
      end
   end

   // Drive pixel at linear index p until accepted; record it and push its expected column.
   task automatic send_px(input int p, input bit rnd, input bit gaps);
      int   r = p / W;
      int   c = p % W;
      int   t = 0;
      exp_t e;
      if (gaps && $urandom_range(0, 9) < 3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = rnd ? DW'($urandom) : DW'(r * 16 + c);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            check("accept_timeout", 32'(0), 32'(1));
            break;
         end
      end
      img[r][c] = in_data;
      if (r >= 2) begin
         e.done = (r == H - 1) && (c == W - 1);
         e.col  = CW'(c);
         e.r0   = img[r-2][c];
         e.r1   = img[r-1][c];
         e.r2   = in_data;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input bit rnd, input bit gaps);
      for (int p = first; p <= last; p++) send_px(p, rnd, gaps);
   endtask

   // sof together with in_valid in IDLE: the beat must not be accepted.
   task automatic start_frame();
      sof      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
      check("ready_at_sof", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      sof      = 1'b0;
      in_valid = 1'b0;
      check("ready_after_sof", 32'(in_ready), 32'(1));
   endtask

   task automatic end_frame(input int base);
      repeat (3) @(posedge clk);
      #1;
      check("out_count", 32'(n_out - base), 32'((H - 2) * W));
      check("sb_drained", 32'(sb.size()), 32'(0));
      check("f0_empty_end", 32'(c0), 32'(0));
      check("f1_empty_end", 32'(c1), 32'(0));
      check("err_end", 32'(err), 32'(0));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_frame_done", 32'(frame_done), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_wr_en", 32'({fifo_bus.f0_wr_en, fifo_bus.f1_wr_en}), 32'(0));
      check("rst_rd_en", 32'({fifo_bus.f0_rd_en, fifo_bus.f1_rd_en}), 32'(0));
      check("rst_out_col", 32'(out_col), 32'(0));
      check("rst_out_r2", 32'(out_r2), 32'(0));
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int base;
      #2;
      apply_reset();

      // Fixed pattern, continuous stream.
      base = n_out;
      start_frame();
      send_range(0, W * H - 1, 1'b0, 1'b0);
      end_frame(base);

      // Random data with idle gaps.
      for (int f = 0; f < 4; f++) begin
         base = n_out;
         start_frame();
         send_range(0, W * H - 1, 1'b1, 1'b1);
         end_frame(base);
      end

      // f0_full mid-row: in_ready drops combinationally and no beat is lost.
      base = n_out;
      start_frame();
      send_range(0, 5, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      frc_f0_full = 1'b1;
      in_valid    = 1'b1;
      #1;
      check("full_ready_drop", 32'(in_ready), 32'(0));
      repeat (3) begin
         @(negedge clk);
         check("full_ready_hold", 32'(in_ready), 32'(0));
      end
      @(posedge clk);
      #1;
      frc_f0_full = 1'b0;
      send_range(6, W * H - 1, 1'b1, 1'b0);
      end_frame(base);

`ifdef MATRIX_WIN_CTRL_ERR_CHK_EN
      // Reading FIFO 1 while it flags empty enters ERR; sof clears it.
      start_frame();
      send_range(0, 2 * W - 1, 1'b1, 1'b0);
      frc_f1_empty = 1'b1;
      send_px(2 * W, 1'b1, 1'b0);
      check("err_set", 32'(err), 32'(1));
      check("err_ready", 32'(in_ready), 32'(0));
      frc_f1_empty = 1'b0;
      @(posedge clk);
      #1;
      sof = 1'b1;
      @(posedge clk);
      #1;
      sof = 1'b0;
      check("err_clear", 32'(err), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      apply_reset();
`endif

      // Async reset mid-frame, then a clean fixed-pattern frame.
      start_frame();
      send_range(0, 2 * W + 1, 1'b1, 1'b0);
      apply_reset();
      base = n_out;
      start_frame();
      send_range(0, W * H - 1, 1'b0, 1'b0);
      end_frame(base);

      // sof during RUN is ignored.
      base = n_out;
      start_frame();
      send_range(0, 2 * W + 1, 1'b1, 1'b0);
      sof = 1'b1;
      send_px(2 * W + 2, 1'b1, 1'b0);
      sof = 1'b0;
      send_range(2 * W + 3, W * H - 1, 1'b1, 1'b0);
      end_frame(base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
